// File: rtl/da_bus_rx.sv
// Receive end of the dual-DAC parallel write bus: synchronizer, channel registers, counters, FIFO.
// Optional channel A period measurement is enabled by defining DA_RX_PERIOD_MEAS_EN.
module da_bus_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          clk_50MHz,
    input  logic                          rst_n,
    input  logic                          DAC_A_B_s,
    input  logic                          da_cs,
    input  logic                          da_wr,
    input  logic [DATA_W-1:0]             da_data,
    output logic [DATA_W-1:0]             ch_a_data,
    output logic [DATA_W-1:0]             ch_b_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_ch,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [CNT_W-1:0]              wr_cnt_a,
    output logic [CNT_W-1:0]              wr_cnt_b,
    output logic [CNT_W-1:0]              period_out,
    output logic                          period_valid
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic              r_wr_s1, r_wr_s2, r_wr_s3;
    logic              r_cs_s1, r_cs_s2;
    logic              r_ab_s1, r_ab_s2;
    logic [DATA_W-1:0] r_data_s1, r_data_s2;
    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wptr, r_rptr;
    logic              w_wr_evt, w_empty, w_full, w_pop, w_push;
    logic [DATA_W:0]   w_head;

    // wr/cs stages reset high so reset release never looks like a strobe edge.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wr_s3   <= 1'b1;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_ab_s1   <= 1'b0;
            r_ab_s2   <= 1'b0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_wr_s1   <= da_wr;
            r_wr_s2   <= r_wr_s1;
            r_wr_s3   <= r_wr_s2;
            r_cs_s1   <= da_cs;
            r_cs_s2   <= r_cs_s1;
            r_ab_s1   <= DAC_A_B_s;
            r_ab_s2   <= r_ab_s1;
            r_data_s1 <= da_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_wr_evt = r_wr_s2 & ~r_wr_s3 & ~r_cs_s2;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            ch_a_data <= '0;
            ch_b_data <= '0;
            wr_cnt_a  <= '0;
            wr_cnt_b  <= '0;
        end else if (w_wr_evt) begin
            if (r_ab_s2) begin
                ch_b_data <= r_data_s2;
                wr_cnt_b  <= wr_cnt_b + 1'b1;
            end else begin
                ch_a_data <= r_data_s2;
                wr_cnt_a  <= wr_cnt_a + 1'b1;
            end
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = ~w_empty & out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the write.
    assign w_push  = w_wr_evt & (~w_full | w_pop);

    always_ff @(posedge clk_50MHz) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {r_ab_s2, r_data_s2};
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_wr_evt && w_full && !w_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rptr[AW-1:0]];

    always_comb begin
        out_valid  = ~w_empty;
        out_ch     = 1'b0;
        out_data   = '0;
        fifo_level = r_wptr - r_rptr;
        if (!w_empty) begin
            out_ch   = w_head[DATA_W];
            out_data = w_head[DATA_W-1:0];
        end
    end

`ifdef DA_RX_PERIOD_MEAS_EN
    logic [CNT_W-1:0] r_clk_cnt;
    logic             r_armed;
    logic             w_crossing;

    assign w_crossing = w_wr_evt & ~r_ab_s2 & ~ch_a_data[DATA_W-1] & r_data_s2[DATA_W-1];

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt    <= '0;
            r_armed      <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_crossing) begin
                r_clk_cnt <= '0;
                r_armed   <= 1'b1;
                if (r_armed) begin
                    period_out   <= (r_clk_cnt == '1) ? '1 : r_clk_cnt + 1'b1;
                    period_valid <= 1'b1;
                end
            end else if (r_clk_cnt != '1) begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end
`else
    assign period_out   = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_da_bus_rx.sv
// Directed self-checking bench for da_bus_rx; period checks follow DA_RX_PERIOD_MEAS_EN.
module tb_da_bus_rx;

    logic        clk_50MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        DAC_A_B_s = 1'b0;
    logic        da_cs = 1'b1;
    logic        da_wr = 1'b1;
    logic [7:0]  da_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  ch_a_data, ch_b_data, out_data;
    logic        out_valid, out_ch, overflow, period_valid;
    logic [4:0]  fifo_level;
    logic [31:0] wr_cnt_a, wr_cnt_b, period_out;

    int n_tests = 0;
    int n_fail  = 0;

    da_bus_rx #(.DATA_W(8), .FIFO_DEPTH(16), .CNT_W(32)) dut (
        .clk_50MHz   (clk_50MHz),
        .rst_n       (rst_n),
        .DAC_A_B_s   (DAC_A_B_s),
        .da_cs       (da_cs),
        .da_wr       (da_wr),
        .da_data     (da_data),
        .ch_a_data   (ch_a_data),
        .ch_b_data   (ch_b_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .wr_cnt_a    (wr_cnt_a),
        .wr_cnt_b    (wr_cnt_b),
        .period_out  (period_out),
        .period_valid(period_valid)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    // One bus write: wr low 3 clocks, high 4; optionally assert out_ready in the event cycle.
    task automatic bus_write(input logic ab, input logic [7:0] d, input logic cs, input logic pop);
        da_cs     = cs;
        DAC_A_B_s = ab;
        da_data   = d;
        da_wr     = 1'b0;
        repeat (3) step();
        da_wr = 1'b1;
        step();
        step();
        if (pop) out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            da_wr   = i[0];
            da_cs   = i[1];
            da_data = 8'(i * 37);
            step();
        end
        n_tests++; if (ch_a_data !== 8'h00) begin n_fail++; $display("FAIL reset_ch_a got %0h exp 0", ch_a_data); end
        n_tests++; if (ch_b_data !== 8'h00) begin n_fail++; $display("FAIL reset_ch_b got %0h exp 0", ch_b_data); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
        n_tests++; if (wr_cnt_a !== 32'd0 || wr_cnt_b !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", wr_cnt_a, wr_cnt_b); end
        n_tests++; if (period_out !== 32'd0 || period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_period got %0d/%0b exp 0/0", period_out, period_valid); end
        da_wr = 1'b1;
        da_cs = 1'b0;
        rst_n = 1'b1;
        repeat (5) step();
        n_tests++; if (wr_cnt_a !== 32'd0 || wr_cnt_b !== 32'd0) begin n_fail++; $display("FAIL release_cnt got %0d/%0d exp 0/0", wr_cnt_a, wr_cnt_b); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid got %0b exp 0", out_valid); end
    endtask

    task automatic test_single_write();
        da_cs     = 1'b0;
        DAC_A_B_s = 1'b0;
        da_data   = 8'hA5;
        da_wr     = 1'b0;
        repeat (3) step();
        da_wr = 1'b1;
        step();
        step();
        n_tests++; if (ch_a_data !== 8'h00) begin n_fail++; $display("FAIL single_early_ch_a got %0h exp 0", ch_a_data); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %0b exp 0", out_valid); end
        step();
        n_tests++; if (ch_a_data !== 8'hA5) begin n_fail++; $display("FAIL single_ch_a got %0h exp a5", ch_a_data); end
        n_tests++; if (wr_cnt_a !== 32'd1) begin n_fail++; $display("FAIL single_cnt_a got %0d exp 1", wr_cnt_a); end
        n_tests++; if (wr_cnt_b !== 32'd0) begin n_fail++; $display("FAIL single_cnt_b got %0d exp 0", wr_cnt_b); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        n_tests++; if (out_ch !== 1'b0 || out_data !== 8'hA5) begin n_fail++; $display("FAIL single_head got %0b/%0h exp 0/a5", out_ch, out_data); end
        n_tests++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", fifo_level); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL single_pop got %0b/%0d exp 0/0", out_valid, fifo_level); end
        step();
    endtask

    task automatic test_cs_high();
        bus_write(1'b0, 8'h3C, 1'b1, 1'b0);
        n_tests++; if (ch_a_data !== 8'hA5) begin n_fail++; $display("FAIL cs_ch_a got %0h exp a5", ch_a_data); end
        n_tests++; if (ch_b_data !== 8'h00) begin n_fail++; $display("FAIL cs_ch_b got %0h exp 0", ch_b_data); end
        n_tests++; if (wr_cnt_a !== 32'd1 || wr_cnt_b !== 32'd0) begin n_fail++; $display("FAIL cs_cnt got %0d/%0d exp 1/0", wr_cnt_a, wr_cnt_b); end
        n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL cs_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) bus_write(1'b1, 8'(i), 1'b0, 1'b0);
        n_tests++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at16 got %0d/%0b exp 16/0", fifo_level, overflow); end
        bus_write(1'b1, 8'd16, 1'b0, 1'b0);
        n_tests++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d exp 16", fifo_level); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        n_tests++; if (wr_cnt_b !== 32'd17) begin n_fail++; $display("FAIL ovf_cnt_b got %0d exp 17", wr_cnt_b); end
        n_tests++; if (ch_b_data !== 8'h10) begin n_fail++; $display("FAIL ovf_ch_b got %0h exp 10", ch_b_data); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_ch !== 1'b1 || out_data !== 8'(i)) begin
                n_fail++; $display("FAIL ovf_drain%0d got %0b/%0b/%0h exp 1/1/%0h", i, out_valid, out_ch, out_data, i);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %0b exp 0", out_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %0b exp 0", overflow); end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 16; i++) bus_write(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        bus_write(1'b1, 8'h77, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %0b exp 0", overflow); end
        n_tests++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL fpp_level got %0d exp 16", fifo_level); end
        n_tests++; if (wr_cnt_b !== 32'd34) begin n_fail++; $display("FAIL fpp_cnt_b got %0d exp 34", wr_cnt_b); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 15) ? 8'h77 : 8'h81 + 8'(i);
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
                n_fail++; $display("FAIL fpp_drain%0d got %0b/%0h exp 1/%0h", i, out_valid, out_data, exp_d);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        n_tests++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL fpp_empty got %0b/%0d exp 0/0", out_valid, fifo_level); end
    endtask

    task automatic test_reset_mid();
        bus_write(1'b0, 8'h11, 1'b0, 1'b0);
        bus_write(1'b0, 8'h22, 1'b0, 1'b0);
        n_tests++; if (fifo_level !== 5'd2 || wr_cnt_a !== 32'd3) begin n_fail++; $display("FAIL mid_pre got %0d/%0d exp 2/3", fifo_level, wr_cnt_a); end
        #3 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL mid_fifo got %0b/%0d exp 0/0", out_valid, fifo_level); end
        n_tests++; if (wr_cnt_a !== 32'd0 || wr_cnt_b !== 32'd0 || ch_a_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_regs got %0d/%0d/%0h exp 0/0/0", wr_cnt_a, wr_cnt_b, ch_a_data);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Ramp 0..255 on channel A, one write per 4 clocks, three times: crossings 1024 clocks apart.
    task automatic test_period();
        int n_pulses = 0;
        out_ready = 1'b1;
        da_cs     = 1'b0;
        DAC_A_B_s = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 256; v++) begin
                da_data = 8'(v);
                for (int c = 0; c < 4; c++) begin
                    da_wr = (c >= 2);
                    step();
                    if (period_valid === 1'b1) begin
                        n_pulses++;
                        n_tests++; if (period_out !== 32'd1024) begin n_fail++; $display("FAIL period_val got %0d exp 1024", period_out); end
                    end
                end
            end
        end
        da_wr = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        n_tests++; if (ch_a_data !== 8'hFF) begin n_fail++; $display("FAIL period_ch_a got %0h exp ff", ch_a_data); end
`ifdef DA_RX_PERIOD_MEAS_EN
        n_tests++; if (n_pulses !== 2) begin n_fail++; $display("FAIL period_pulses got %0d exp 2", n_pulses); end
`else
        n_tests++; if (n_pulses !== 0 || period_out !== 32'd0) begin n_fail++; $display("FAIL period_off got %0d/%0d exp 0/0", n_pulses, period_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_cs_high();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        test_period();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
